// File: rtl/lvds_rx_deser.sv
// lvds_rx_deser: soft single-lane serial-to-parallel receiver with bit-slip word alignment.
// Optional loss-of-signal detection while LOCKED is built in when LVDS_RX_LOS_DET_EN is defined.
module lvds_rx_deser #(
    parameter int unsigned      WIDTH         = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'h6A),
    parameter int unsigned      LOCK_COUNT    = 4
) (
    input  logic                     CLK,
    input  logic                     LSR,
    input  logic                     SDI,
    input  logic                     ALIGN,
    output logic [WIDTH-1:0]         Q,
    output logic                     Q_VALID,
    output logic                     LOCKED,
    output logic [$clog2(WIDTH)-1:0] SLIP_CNT
);
    localparam int unsigned    BCW        = $clog2(WIDTH);
    localparam logic [BCW-1:0] BC_LAST    = BCW'(WIDTH - 1);
    localparam logic [3:0]     MATCH_LAST = 4'(LOCK_COUNT - 1);

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-2:0] sr_q;
    logic [BCW-1:0]   bc_q;
    logic             slip_hold_q, slip_d;
    logic [3:0]       match_q, match_d;
    logic [BCW-1:0]   slip_cnt_d;
    logic [WIDTH-1:0] q_d;
    logic             q_valid_d;
    logic             boundary;
    logic             realign;
    logic             los_trip;
    logic [WIDTH-1:0] word;

    assign boundary = (bc_q == BC_LAST);
    assign word     = {sr_q, SDI};
    assign LOCKED   = (state_q == S_LOCKED);

`ifdef LVDS_RX_LOS_DET_EN
    logic [4:0] los_q, los_d;

    // A full run of 16 stuck words acts like an ALIGN request on the following cycle.
    assign los_trip = (los_q == 5'd16);

    always_comb begin
        los_d = los_q;
        if (!LOCKED || realign)
            los_d = '0;
        else if (boundary)
            los_d = ((&word) || !(|word)) ? los_q + 5'd1 : '0;
    end

    always_ff @(posedge CLK) begin
        if (LSR)
            los_q <= '0;
        else
            los_q <= los_d;
    end
`else
    assign los_trip = 1'b0;
`endif

    assign realign = ALIGN | los_trip;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        slip_cnt_d = SLIP_CNT;
        slip_d     = 1'b0;
        q_d        = Q;
        q_valid_d  = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (ALIGN) begin
                    match_d    = '0;
                    slip_cnt_d = '0;
                end else if (boundary) begin
                    if (word == TRAIN_PATTERN) begin
                        match_d = match_q + 4'd1;
                        if (match_q == MATCH_LAST)
                            state_d = S_LOCKED;
                    end else begin
                        match_d    = '0;
                        slip_d     = 1'b1;
                        slip_cnt_d = SLIP_CNT + BCW'(1);
                    end
                end
            end
            S_LOCKED: begin
                if (boundary) begin
                    q_d       = word;
                    q_valid_d = 1'b1;
                end
                // A boundary coinciding with realign still delivers its word above.
                if (realign) begin
                    state_d    = S_HUNT;
                    match_d    = '0;
                    slip_cnt_d = '0;
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    // NOTE: the shift register has no reset; a boundary only consumes samples taken after reset release.
    always_ff @(posedge CLK) begin
        sr_q <= {sr_q[WIDTH-3:0], SDI};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (LSR) begin
            state_q     <= S_HUNT;
            bc_q        <= '0;
            slip_hold_q <= 1'b0;
            match_q     <= '0;
            SLIP_CNT    <= '0;
            Q           <= '0;
            Q_VALID     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slip_hold_q <= slip_d;
            match_q     <= match_d;
            SLIP_CNT    <= slip_cnt_d;
            Q           <= q_d;
            Q_VALID     <= q_valid_d;
            // A slip parks the counter at 0 for one extra cycle, moving the window one bit later.
            if (slip_hold_q || boundary)
                bc_q <= '0;
            else
                bc_q <= bc_q + BCW'(1);
        end
    end

endmodule

// File: tb/tb_lvds_rx_deser.sv
// tb_lvds_rx_deser: directed self-checking bench for lvds_rx_deser (WIDTH=8, 0x6A, LOCK_COUNT=4).
// Loss-of-signal expectations follow LVDS_RX_LOS_DET_EN.
module tb_lvds_rx_deser;
    localparam int DATA_OFF = 3;

    logic       CLK     = 1'b0;
    logic       LSR     = 1'b1;
    logic       SDI     = 1'b0;
    logic       ALIGN   = 1'b0;
    logic [7:0] Q;
    logic       Q_VALID;
    logic       LOCKED;
    logic [2:0] SLIP_CNT;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         vcyc[$];
    logic [7:0] vq[$];

    lvds_rx_deser #(
        .WIDTH        (8),
        .TRAIN_PATTERN(8'h6A),
        .LOCK_COUNT   (4)
    ) dut (
        .CLK     (CLK),
        .LSR     (LSR),
        .SDI     (SDI),
        .ALIGN   (ALIGN),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .LOCKED  (LOCKED),
        .SLIP_CNT(SLIP_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_q"},        32'(Q),        32'h0);
        check({tag, "_q_valid"},  32'(Q_VALID),  32'h0);
        check({tag, "_locked"},   32'(LOCKED),   32'h0);
        check({tag, "_slip_cnt"}, 32'(SLIP_CNT), 32'h0);
    endtask

    // Bit sent on cycle c of a 0x6A stream whose word MSBs fall on cycles off, off+8, ...
    function automatic logic train_bit(input int c, input int off);
        logic [7:0] p;
        int         idx;
        p   = 8'h6A;
        idx = ((c - off) % 8 + 8) % 8;
        return p[7-idx];
    endfunction

    // Three LSR cycles with random SDI; next tick is cycle 0.
    task automatic do_reset();
        @(negedge CLK);
        LSR   = 1'b1;
        ALIGN = 1'b0;
        SDI   = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            SDI = 1'($urandom);
            check_idle("rst");
        end
        cyc = -1;
        vq.delete();
        vcyc.delete();
    endtask

    // Outputs are registered, so values seen after driving belong to the cycle just entered.
    task automatic tick(input logic sdi, input logic align);
        @(negedge CLK);
        LSR   = 1'b0;
        SDI   = sdi;
        ALIGN = align;
        cyc++;
        if (Q_VALID) begin
            vq.push_back(Q);
            vcyc.push_back(cyc);
        end
    endtask

    initial begin
        int         lock_at;
        int         lock_cyc;
        int         errs;
        int         lost;
        int         bnd;
        logic [7:0] wk;

        // Reset, then the first post-reset cycle
        do_reset();
        tick(train_bit(0, 0), 1'b0);
        check_idle("rst_c0");

        // Training at every offset: 9 cycles per slip, then 4 matches
        for (int o = 0; o < 8; o++) begin
            lock_at  = 32 + 9 * o;
            lock_cyc = -1;
            do_reset();
            for (int c = 0; c <= lock_at + 8; c++) begin
                tick(train_bit(c, o), 1'b0);
                if (LOCKED && lock_cyc < 0)
                    lock_cyc = cyc;
                if (cyc == lock_at)
                    check($sformatf("slip_cnt_off%0d", o), 32'(SLIP_CNT), 32'(o));
            end
            check($sformatf("lock_cyc_off%0d", o), 32'(lock_cyc), 32'(lock_at));
            check($sformatf("first_vld_cyc_off%0d", o),
                  (vcyc.size() > 0) ? 32'(vcyc[0]) : 32'hFFFF_FFFF, 32'(lock_at + 8));
            check($sformatf("first_vld_q_off%0d", o),
                  (vq.size() > 0) ? 32'(vq[0]) : 32'hFFFF_FFFF, 32'h6A);
        end

        // Locked with 3 slips, then words 0x00..0xFF
        lock_at = 32 + 9 * DATA_OFF;
        do_reset();
        for (int c = 0; c < lock_at; c++)
            tick(train_bit(c, DATA_OFF), 1'b0);
        lost = 0;
        for (int k = 0; k < 256; k++) begin
            wk = 8'(k);
            for (int b = 7; b >= 0; b--) begin
                tick(wk[b], 1'b0);
                if (!LOCKED)
                    lost++;
            end
        end
        check("data_lock_lost", 32'(lost), 32'h0);

        // One more training word with ALIGN on its boundary cycle
        for (int b = 7; b >= 0; b--)
            tick(train_bit(cyc + 1, DATA_OFF), (b == 0));
        bnd = cyc;
        check("align_bnd_cyc",     32'(bnd),      32'(lock_at + 2055));
        check("pre_align_slip",    32'(SLIP_CNT), 32'(DATA_OFF));
        check("pre_align_locked",  32'(LOCKED),   32'h1);
        errs = 0;
        for (int i = 0; i < vq.size(); i++)
            if (vq[i] !== 8'(i) || vcyc[i] != lock_at + 8 + 8 * i)
                errs++;
        check("data_count", 32'(vq.size()), 32'd256);
        check("data_order", 32'(errs),      32'h0);

        tick(train_bit(cyc + 1, DATA_OFF), 1'b0);
        check("align_q_valid",  32'(Q_VALID),  32'h1);
        check("align_q",        32'(Q),        32'h6A);
        check("align_locked",   32'(LOCKED),   32'h0);
        check("align_slip_cnt", 32'(SLIP_CNT), 32'h0);

        while (cyc < bnd + 36) begin
            tick(train_bit(cyc + 1, DATA_OFF), 1'b0);
            if (cyc == bnd + 32)
                check("relock_early", 32'(LOCKED), 32'h0);
            if (cyc == bnd + 33) begin
                check("relock",          32'(LOCKED),   32'h1);
                check("relock_slip_cnt", 32'(SLIP_CNT), 32'h0);
            end
        end

        // LSR in the middle of a word
        check("pre_lsr_locked", 32'(LOCKED), 32'h1);
        check("pre_lsr_q",      32'(Q),      32'h6A);
        @(negedge CLK);
        LSR = 1'b1;
        cyc++;
        @(negedge CLK);
        cyc++;
        check_idle("lsr_mid");

        // 16 stuck words of 0xFF after an aligned lock
        do_reset();
        for (int c = 0; c < 32; c++)
            tick(train_bit(c, 0), 1'b0);
        for (int k = 0; k < 16 * 8; k++)
            tick(1'b1, 1'b0);
        tick(train_bit(cyc + 1, 0), 1'b0);
        check("los16_q_valid", 32'(Q_VALID), 32'h1);
        check("los16_q",       32'(Q),       32'hFF);
        check("los16_locked",  32'(LOCKED),  32'h1);
        tick(train_bit(cyc + 1, 0), 1'b0);
`ifdef LVDS_RX_LOS_DET_EN
        check("los16_drop", 32'(LOCKED), 32'h0);

        // 15 stuck words, 0x5A, then 15 more: the run restarts and lock holds
        do_reset();
        for (int c = 0; c < 32; c++)
            tick(train_bit(c, 0), 1'b0);
        for (int k = 0; k < 15 * 8; k++)
            tick(1'b1, 1'b0);
        wk = 8'h5A;
        for (int b = 7; b >= 0; b--)
            tick(wk[b], 1'b0);
        for (int k = 0; k < 15 * 8; k++)
            tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("los15_q_valid", 32'(Q_VALID), 32'h1);
        check("los15_q",       32'(Q),       32'hFF);
        tick(1'b1, 1'b0);
        check("los15_hold", 32'(LOCKED), 32'h1);
        errs = 0;
        for (int i = 0; i < vq.size(); i++)
            if (vq[i] !== ((i == 15) ? 8'h5A : 8'hFF))
                errs++;
        check("los15_words", 32'(errs), 32'h0);
`else
        check("stuck_words_hold", 32'(LOCKED), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
